snake_game_master_fsm: RTL and testbench

Parametrised master state machine for the snake game. It sequences IDLE, PLAY, PAUSE, WIN and LOSE from the push-buttons, the score, the body-collision flag and an internal play-time countdown. It drives the game-wide `Play_State` consumed by the navigation, food, score and VGA blocks. Unlike the previous master FSM, it edge-detects buttons, supports pause/resume and restart, has a configurable win score and play time, and reports the start direction and a game-over pulse.

---
 rtl/snake_game_master_fsm.sv | 169 ++++++++++++++++
 tb/tb_snake_game_master_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_master_fsm.sv
// ---------------------------------------------------------------------------
// snake_game_master_fsm
//
// This is the master sequencer for the snake game. It steps through IDLE,
// PLAY, PAUSE, WIN and LOSE. The inputs that drive it are the push-buttons
// (edge-detected here), the score, the body-collision flag and an internal
// play-time countdown that advances on TICK.
//
// Ports
//   CLK, RESET              clock and synchronous active-high reset
//   BTNU/BTND/BTNL/BTNR     direction buttons (debounced levels)
//   BTNC                    centre button: pause / resume / restart
//   Score [SCORE_W]         current score, unsigned
//   Body_hit                head-hits-body flag, level
//   TICK                    one-cycle time-base strobe
//   Play_State [3]          IDLE=0 PLAY=1 WIN=2 LOSE=3 PAUSE=4 (registered)
//   Time_Left [TIME_W]      remaining play time (registered)
//   Start_Dir [2]           U=0 D=1 L=2 R=3 of the starting press (registered)
//   Game_Over               one-cycle pulse on entry to WIN or LOSE (registered)
// ---------------------------------------------------------------------------
module snake_game_master_fsm #(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 3,
  parameter int TIME_W    = 8,
  parameter int PLAY_TIME = 60
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BTNU,
  input  logic               BTND,
  input  logic               BTNL,
  input  logic               BTNR,
  input  logic               BTNC,
  input  logic [SCORE_W-1:0] Score,
  input  logic               Body_hit,
  input  logic               TICK,
  output logic [2:0]         Play_State,
  output logic [TIME_W-1:0]  Time_Left,
  output logic [1:0]         Start_Dir,
  output logic               Game_Over
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_WIN   = 3'd2;
  localparam logic [2:0] ST_LOSE  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  localparam logic [TIME_W-1:0]  TIME_LOAD = TIME_W'(PLAY_TIME);
  localparam logic [SCORE_W-1:0] WIN_LIMIT = SCORE_W'(WIN_SCORE);

  // Button vector: 0=U 1=D 2=L 3=R 4=C
  logic [4:0] btn;
  logic [4:0] btn_prev_reg;
  logic [4:0] btn_edge;

  assign btn = {BTNC, BTNR, BTNL, BTND, BTNU};

  // The previous-value registers reset to 1. A button held through reset
  // therefore needs a release and a fresh press before it counts as an edge.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn_edge
      always_ff @(posedge CLK) begin
        if (RESET) begin
          btn_prev_reg[gi] <= 1'b1;
        end else begin
          btn_prev_reg[gi] <= btn[gi];
        end
      end
      assign btn_edge[gi] = btn[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  logic [3:0] dir_edge;
  logic       c_edge;
  logic       win_cond;
  logic       timeout_cond;

  assign dir_edge = btn_edge[3:0];
  assign c_edge   = btn_edge[4];

  logic [2:0]        state_reg, state_next;
  logic [TIME_W-1:0] time_reg, time_next;
  logic [1:0]        dir_reg, dir_next;
  logic              game_over_reg, game_over_next;

  assign win_cond     = (Score >= WIN_LIMIT);
  assign timeout_cond = TICK && (time_reg == TIME_W'(1));

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      time_reg      <= TIME_LOAD;
      dir_reg       <= 2'd0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      time_reg      <= time_next;
      dir_reg       <= dir_next;
      game_over_reg <= game_over_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|dir_edge) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // Priority: win, body hit, timeout, pause
        if (win_cond)          state_next = ST_WIN;
        else if (Body_hit)     state_next = ST_LOSE;
        else if (timeout_cond) state_next = ST_LOSE;
        else if (c_edge)       state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (c_edge) state_next = ST_PLAY;
      end
      ST_WIN, ST_LOSE: begin
        if (c_edge) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    time_next      = time_reg;
    dir_next       = dir_reg;
    game_over_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        time_next = TIME_LOAD;
        if (dir_edge[0])      dir_next = 2'd0;
        else if (dir_edge[1]) dir_next = 2'd1;
        else if (dir_edge[2]) dir_next = 2'd2;
        else if (dir_edge[3]) dir_next = 2'd3;
      end
      ST_PLAY: begin
        // A tick that coincides with a win or a body hit is not consumed.
        // The non-zero guard keeps the counter from wrapping.
        if (!win_cond && !Body_hit && TICK && (time_reg != '0)) begin
          time_next = time_reg - TIME_W'(1);
        end
        game_over_next = (state_next == ST_WIN) || (state_next == ST_LOSE);
      end
      ST_PAUSE: begin
        time_next = time_reg;
      end
      ST_WIN, ST_LOSE: begin
        if (c_edge) time_next = TIME_LOAD;
      end
      default: begin
        // Recovery from an illegal code: outputs take their IDLE values.
        time_next = TIME_LOAD;
        dir_next  = 2'd0;
      end
    endcase
  end

  assign Play_State = state_reg;
  assign Time_Left  = time_reg;
  assign Start_Dir  = dir_reg;
  assign Game_Over  = game_over_reg;

endmodule

// File: tb/tb_snake_game_master_fsm.sv
// ---------------------------------------------------------------------------
// Testbench for snake_game_master_fsm. It drives two instances from the same
// stimulus: one with default parameters (PLAY_TIME=60) and one with
// PLAY_TIME=3, which covers the timeout path. Inputs change 1 ns after the
// rising edge, and outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_snake_game_master_fsm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTNC = 1'b0;
  logic [3:0] Score = 4'd0;
  logic       Body_hit = 1'b0;
  logic       TICK = 1'b0;

  logic [2:0] play_state_a, play_state_b;
  logic [7:0] time_left_a, time_left_b;
  logic [1:0] start_dir_a, start_dir_b;
  logic       game_over_a, game_over_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  snake_game_master_fsm dut (
    .CLK(CLK), .RESET(RESET),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
    .Score(Score), .Body_hit(Body_hit), .TICK(TICK),
    .Play_State(play_state_a), .Time_Left(time_left_a),
    .Start_Dir(start_dir_a), .Game_Over(game_over_a)
  );

  snake_game_master_fsm #(.PLAY_TIME(3)) dut3 (
    .CLK(CLK), .RESET(RESET),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
    .Score(Score), .Body_hit(Body_hit), .TICK(TICK),
    .Play_State(play_state_b), .Time_Left(time_left_b),
    .Start_Dir(start_dir_b), .Game_Over(game_over_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Advance one clock; afterwards we are 1 ns past the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tick_pulse();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
  endtask

  initial begin
    // Reset
    step(2);
    RESET = 1'b0;
    step();
    check("rst_state", play_state_a, 0);
    check("rst_time", time_left_a, 60);
    check("rst_dir", start_dir_a, 0);
    check("rst_gameover", game_over_a, 0);
    check("rst_time_pt3", time_left_b, 3);

    // Left press starts the game; holding it gives no further change
    BTNL = 1'b1;
    step();
    check("start_l_state", play_state_a, 1);
    check("start_l_dir", start_dir_a, 2);
    check("start_l_time", time_left_a, 60);
    step(10);
    check("hold_l_state", play_state_a, 1);
    check("hold_l_time", time_left_a, 60);
    BTNL = 1'b0;
    step();

    // Win on score, Game_Over pulse, restart by BTNC
    Score = 4'd3;
    step();
    check("win_state", play_state_a, 2);
    check("win_gameover", game_over_a, 1);
    step();
    check("win_gameover_end", game_over_a, 0);
    check("win_hold_state", play_state_a, 2);
    Score = 4'd0;
    BTNC = 1'b1;
    step();
    check("restart_state", play_state_a, 0);
    check("restart_time", time_left_a, 60);
    BTNC = 1'b0;
    step();

    // Timeout with PLAY_TIME=3 on dut3
    BTNU = 1'b1;
    step();
    check("pt3_start_state", play_state_b, 1);
    check("pt3_start_time", time_left_b, 3);
    check("pt3_start_dir", start_dir_b, 0);
    BTNU = 1'b0;
    tick_pulse();
    check("pt3_tick1_time", time_left_b, 2);
    check("dflt_tick1_time", time_left_a, 59);
    tick_pulse();
    check("pt3_tick2_time", time_left_b, 1);
    check("pt3_tick2_state", play_state_b, 1);
    tick_pulse();
    check("pt3_tick3_state", play_state_b, 3);
    check("pt3_tick3_time", time_left_b, 0);
    check("pt3_tick3_gameover", game_over_b, 1);
    step();
    check("pt3_gameover_end", game_over_b, 0);
    check("pt3_lose_time_hold", time_left_b, 0);

    // Pause: everything except BTNC is ignored; a held BTNC does not resume
    check("pre_pause_time", time_left_a, 57);
    BTNC = 1'b1;
    step();
    check("pause_state", play_state_a, 4);
    Body_hit = 1'b1;
    Score = 4'd5;
    for (int i = 0; i < 5; i++) tick_pulse();
    check("pause_hold_state", play_state_a, 4);
    check("pause_hold_time", time_left_a, 57);
    check("pause_no_gameover", game_over_a, 0);
    Body_hit = 1'b0;
    Score = 4'd0;
    BTNC = 1'b0;
    step();
    BTNC = 1'b1;
    step();
    check("resume_state", play_state_a, 1);
    check("resume_time", time_left_a, 57);
    BTNC = 1'b0;
    step();

    // Run the counter down to 1, then raise every event in the same cycle
    for (int i = 0; i < 56; i++) tick_pulse();
    check("countdown_time", time_left_a, 1);
    check("countdown_state", play_state_a, 1);
    Score = 4'd3;
    Body_hit = 1'b1;
    TICK = 1'b1;
    BTNC = 1'b1;
    step();
    check("simul_state", play_state_a, 2);
    check("simul_time", time_left_a, 1);
    check("simul_gameover", game_over_a, 1);
    Score = 4'd0;
    Body_hit = 1'b0;
    TICK = 1'b0;
    BTNC = 1'b0;
    step();
    BTNC = 1'b1;
    step();
    check("simul_restart_state", play_state_a, 0);
    check("simul_restart_time", time_left_a, 60);
    BTNC = 1'b0;
    step();

    // Coincident U and R edges: U has priority
    BTNU = 1'b1;
    BTNR = 1'b1;
    step();
    check("ur_state", play_state_a, 1);
    check("ur_dir", start_dir_a, 0);
    BTNU = 1'b0;
    BTNR = 1'b0;
    step();

    // Body hit with a coincident tick: LOSE, and the tick is not consumed
    Body_hit = 1'b1;
    TICK = 1'b1;
    step();
    check("hit_state", play_state_a, 3);
    check("hit_time", time_left_a, 60);
    check("hit_gameover", game_over_a, 1);
    Body_hit = 1'b0;
    TICK = 1'b0;
    step();

    // BTNR held through reset: no start until it is released and pressed again
    BTNR = 1'b1;
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(2);
    check("held_r_state", play_state_a, 0);
    BTNR = 1'b0;
    step();
    BTNR = 1'b1;
    step();
    check("repress_r_state", play_state_a, 1);
    check("repress_r_dir", start_dir_a, 3);
    BTNR = 1'b0;
    tick_pulse();
    check("mid_play_time", time_left_a, 59);

    // Reset for one cycle mid-PLAY
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("midrst_state", play_state_a, 0);
    check("midrst_time", time_left_a, 60);
    check("midrst_gameover", game_over_a, 0);
    check("midrst_dir", start_dir_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
